lane_distributor: RTL and testbench

- TX-side counterpart of the RX lane reorder/serializer.
- Accepts one NB_DATA-bit block per valid cycle and distributes consecutive blocks round-robin over N_LANES logical lanes (1-to-N parallelism conversion).
- Presents one full N-lane bus per completed round, double-buffered so input never stalls.
- Sits between the TX scrambler/encoder and per-lane alignment-marker insertion.

---
 rtl/pcs_lane_pkg.sv | 15 +
 rtl/lane_dist_permute.sv | 25 ++
 rtl/lane_distributor.sv | 102 ++++++++++
 tb/tb_lane_distributor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pcs_lane_pkg.sv
// Shared PCS lane constants, idle pad block and lane distributor FSM encoding.
package pcs_lane_pkg;

  localparam int NB_DATA = 66;
  localparam int N_LANES = 20;
  localparam int NB_ID   = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  localparam logic [NB_DATA-1:0] IDLE_BLOCK = {2'b10, 8'h1E, 56'h0};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } lane_dist_state_t;

endpackage

// File: rtl/lane_dist_permute.sv
// Output lane permutation: physical lane k carries logical lane i_lane_ids[k].
// Field 0 is the MSB field; a selector >= N_LANES drives zeros on that lane.
module lane_dist_permute #(
  parameter int NB_DATA = 66,
  parameter int N_LANES = 20,
  parameter int NB_ID   = 5
) (
  input  logic [NB_DATA*N_LANES-1:0] i_data_bus,
  input  logic [NB_ID*N_LANES-1:0]   i_lane_ids,
  output logic [NB_DATA*N_LANES-1:0] o_data_bus
);

  always_comb begin
    int sel;
    o_data_bus = '0;
    sel        = 0;
    for (int k = 0; k < N_LANES; k++) begin
      sel = int'(i_lane_ids[(N_LANES-1-k)*NB_ID +: NB_ID]);
      if (sel < N_LANES)
        o_data_bus[(N_LANES-1-k)*NB_DATA +: NB_DATA] =
          i_data_bus[(N_LANES-1-sel)*NB_DATA +: NB_DATA];
    end
  end

endmodule

// File: rtl/lane_distributor.sv
// Round-robin 1-to-N block distributor with double-buffered N-lane output.
// Define LANE_DIST_SWAP_EN to permute output lanes via i_lane_ids.
module lane_distributor #(
  parameter int NB_DATA     = pcs_lane_pkg::NB_DATA,
  parameter int N_LANES     = pcs_lane_pkg::N_LANES,
  parameter int NB_ID       = (N_LANES > 1) ? $clog2(N_LANES) : 1,
  parameter int NB_DATA_BUS = NB_DATA*N_LANES,
  parameter logic [NB_DATA-1:0] IDLE_BLOCK = pcs_lane_pkg::IDLE_BLOCK
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic                     i_flush,
  input  logic [NB_DATA-1:0]       i_data,
  input  logic [NB_ID*N_LANES-1:0] i_lane_ids,
  output logic [NB_DATA_BUS-1:0]   o_data,
  output logic                     o_valid,
  output logic [NB_ID-1:0]         o_lane_ptr,
  output logic                     o_busy
);
  import pcs_lane_pkg::*;

  lane_dist_state_t       state, state_nxt;
  logic [NB_ID-1:0]       wr_ptr, wr_ptr_nxt;
  logic [NB_DATA-1:0]     fill_buf [N_LANES];
  logic [NB_ID:0]         fill_cnt;
  logic                   accept, flush_req, last, emit;
  logic [NB_DATA_BUS-1:0] round_bus, out_bus;

  assign accept    = i_enable && i_valid;
  assign flush_req = i_enable && i_flush;
  assign last      = accept && (wr_ptr == NB_ID'(N_LANES-1));
  // A flush only closes a round that actually holds at least one block.
  assign emit      = last || (flush_req && ((state == ST_FILL) || accept));
  assign fill_cnt  = {1'b0, wr_ptr} + (NB_ID+1)'(accept);

  always_comb begin
    round_bus = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (accept && (wr_ptr == NB_ID'(k)))
        round_bus[(N_LANES-1-k)*NB_DATA +: NB_DATA] = i_data;
      else if ((NB_ID+1)'(k) < fill_cnt)
        round_bus[(N_LANES-1-k)*NB_DATA +: NB_DATA] = fill_buf[k];
      else
        round_bus[(N_LANES-1-k)*NB_DATA +: NB_DATA] = IDLE_BLOCK;
    end
  end

`ifdef LANE_DIST_SWAP_EN
  lane_dist_permute #(
    .NB_DATA (NB_DATA),
    .N_LANES (N_LANES),
    .NB_ID   (NB_ID)
  ) u_permute (
    .i_data_bus (round_bus),
    .i_lane_ids (i_lane_ids),
    .o_data_bus (out_bus)
  );
`else
  logic unused_lane_ids;
  assign unused_lane_ids = ^i_lane_ids;
  assign out_bus         = round_bus;
`endif

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    case (state)
      ST_IDLE: if (accept && !emit) state_nxt = ST_FILL;
      ST_FILL: if (emit)            state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
    if (emit)
      wr_ptr_nxt = '0;
    else if (accept)
      wr_ptr_nxt = (wr_ptr == NB_ID'(N_LANES-1)) ? '0 : wr_ptr + 1'b1;
  end

  // Stage boundary: fill buffer, FSM and output register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= ST_IDLE;
      wr_ptr  <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      for (int k = 0; k < N_LANES; k++) fill_buf[k] <= '0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      o_valid <= emit;
      if (emit)
        o_data <= out_bus;
      if (accept && !emit)
        fill_buf[wr_ptr] <= i_data;
    end
  end

  assign o_lane_ptr = wr_ptr;
  assign o_busy     = (state == ST_FILL);

endmodule

// File: tb/tb_lane_distributor.sv
// Self-checking bench for lane_distributor (N_LANES=4) against a queue-based round model.
module tb_lane_distributor;

  localparam int NBD = 66;
  localparam int NL  = 4;
  localparam int NI  = 2;
  localparam int BUS = NBD*NL;
  localparam logic [NBD-1:0] IDLE = {2'b10, 8'h1E, 56'h0};

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_enable, i_valid, i_flush;
  logic [NBD-1:0] i_data;
  logic [NI*NL-1:0] i_lane_ids;
  logic [BUS-1:0] o_data;
  logic           o_valid;
  logic [NI-1:0]  o_lane_ptr;
  logic           o_busy;

  int checks = 0;
  int errors = 0;

  logic [NBD-1:0] mq[$];
  logic [BUS-1:0] exp_data;
  logic           exp_valid;
  int             exp_ptr;
  logic           exp_busy;
  int             lane_map [NL] = '{3, 0, 2, 1};

  lane_distributor #(
    .NB_DATA (NBD),
    .N_LANES (NL)
  ) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_enable   (i_enable),
    .i_valid    (i_valid),
    .i_flush    (i_flush),
    .i_data     (i_data),
    .i_lane_ids (i_lane_ids),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_lane_ptr (o_lane_ptr),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NBD-1:0] rand_block();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[NBD-1:0];
  endfunction

  function automatic logic [BUS-1:0] lanes4(input logic [NBD-1:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  // Model: blocks accumulate in a queue; a round is emitted when full or flushed non-empty.
  task automatic step(input bit v, input bit f, input bit en, input logic [NBD-1:0] d);
    int sel;
    i_valid = v; i_flush = f; i_enable = en; i_data = d;
    if (en && v) mq.push_back(d);
    exp_valid = 1'b0;
    if (mq.size() == NL || (en && f && mq.size() > 0)) begin
      while (mq.size() < NL) mq.push_back(IDLE);
      exp_data = '0;
      for (int k = 0; k < NL; k++) begin
`ifdef LANE_DIST_SWAP_EN
        sel = lane_map[k];
`else
        sel = k;
`endif
        if (sel < NL) exp_data[(NL-1-k)*NBD +: NBD] = mq[sel];
      end
      mq.delete();
      exp_valid = 1'b1;
    end
    exp_ptr  = mq.size();
    exp_busy = (mq.size() != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_data = '0; exp_valid = 1'b0; exp_ptr = 0; exp_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_enable = 0; i_valid = 0; i_flush = 0; i_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", o_data); end
    checks++; if (o_lane_ptr !== '0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", o_lane_ptr); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    rst_n = 1'b1;
    step(0, 0, 1, '0);
  endtask

  task automatic test_single_round();
    logic [BUS-1:0] want;
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 1, NBD'(i));
      checks++; if (o_valid !== exp_valid) begin errors++; $display("FAIL round_valid[%0d]: got %b want %b", i, o_valid, exp_valid); end
      checks++; if (o_lane_ptr !== NI'(exp_ptr)) begin errors++; $display("FAIL round_ptr[%0d]: got %0d want %0d", i, o_lane_ptr, exp_ptr); end
      checks++; if (o_busy !== exp_busy) begin errors++; $display("FAIL round_busy[%0d]: got %b want %b", i, o_busy, exp_busy); end
    end
`ifdef LANE_DIST_SWAP_EN
    want = lanes4(66'd4, 66'd1, 66'd3, 66'd2);
`else
    want = lanes4(66'd1, 66'd2, 66'd3, 66'd4);
`endif
    checks++; if (o_data !== want) begin errors++; $display("FAIL round_data: got %h want %h", o_data, want); end
    step(0, 0, 1, '0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL round_pulse_width: got %b want 0", o_valid); end
    checks++; if (o_data !== want) begin errors++; $display("FAIL round_data_hold: got %h want %h", o_data, want); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first = -1, second = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 1, NBD'(i));
      if (o_valid === 1'b1) begin
        if (pulses == 0) first = i; else second = i;
        pulses++;
      end
      checks++; if (o_data !== exp_data) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, o_data, exp_data); end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    checks++; if (second - first != 4) begin errors++; $display("FAIL b2b_spacing: got %0d want 4", second - first); end
  endtask

  task automatic test_flush();
    logic [BUS-1:0] want;
    step(1, 0, 1, 66'd1);
    step(1, 0, 1, 66'd2);
    step(0, 1, 1, '0);
`ifdef LANE_DIST_SWAP_EN
    want = lanes4(IDLE, 66'd1, IDLE, 66'd2);
`else
    want = lanes4(66'd1, 66'd2, IDLE, IDLE);
`endif
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL flush_valid: got %b want 1", o_valid); end
    checks++; if (o_data !== want) begin errors++; $display("FAIL flush_data: got %h want %h", o_data, want); end
    checks++; if (o_lane_ptr !== '0) begin errors++; $display("FAIL flush_ptr: got %0d want 0", o_lane_ptr); end
    step(0, 1, 1, '0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_valid: got %b want 0", o_valid); end
    checks++; if (o_data !== want) begin errors++; $display("FAIL flush_idle_hold: got %h want %h", o_data, want); end
    for (int i = 1; i <= 4; i++) step(1, (i == 4), 1, NBD'(i + 10));
    checks++; if (o_valid !== 1'b1 || o_data !== exp_data) begin errors++; $display("FAIL flush_complete: got %b/%h want 1/%h", o_valid, o_data, exp_data); end
    step(0, 0, 1, '0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_complete_extra: got %b want 0", o_valid); end
  endtask

  task automatic test_enable();
    step(1, 0, 1, 66'd21);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 66'd99);
      checks++; if (o_lane_ptr !== 2'd1) begin errors++; $display("FAIL enable_ptr_hold[%0d]: got %0d want 1", i, o_lane_ptr); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL enable_valid[%0d]: got %b want 0", i, o_valid); end
    end
    step(1, 0, 1, 66'd22);
    step(1, 0, 1, 66'd23);
    step(1, 0, 1, 66'd24);
    checks++; if (o_valid !== 1'b1 || o_data !== exp_data) begin errors++; $display("FAIL enable_round: got %b/%h want 1/%h", o_valid, o_data, exp_data); end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 6; i++) step(1, 0, 1, NBD'(i + 30));
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_data !== '0) begin errors++; $display("FAIL areset_data: got %h want 0", o_data); end
    checks++; if (o_lane_ptr !== '0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL areset_ctrl: got ptr=%0d v=%b busy=%b want 0", o_lane_ptr, o_valid, o_busy); end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) step(1, 0, 1, NBD'(i + 40));
    checks++; if (o_valid !== 1'b1 || o_data !== exp_data) begin errors++; $display("FAIL areset_round: got %b/%h want 1/%h", o_valid, o_data, exp_data); end
  endtask

  task automatic test_random();
    bit v, f, en;
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom % 4) != 0;
      f  = ($urandom % 8) == 0;
      en = ($urandom % 8) != 0;
      step(v, f, en, rand_block());
      checks++; if (o_valid !== exp_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, o_valid, exp_valid); end
      checks++; if (o_data !== exp_data) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, o_data, exp_data); end
      checks++; if (o_lane_ptr !== NI'(exp_ptr) || o_busy !== exp_busy) begin errors++; $display("FAIL rand_ptr[%0d]: got %0d/%b want %0d/%b", i, o_lane_ptr, o_busy, exp_ptr, exp_busy); end
    end
  endtask

  initial begin
    i_lane_ids = {2'd3, 2'd0, 2'd2, 2'd1};
    test_reset();
    test_single_round();
    test_back_to_back();
    test_flush();
    test_enable();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
